// File: rtl/data_channel_arbiter.sv
// Round-robin owner arbiter for the shared photonic data channel; grant held until release, then a guard gap.
// Optional hold-time revocation is built when DATA_CHANNEL_ARBITER_TIMEOUT_EN is defined.
module data_channel_arbiter #(
    parameter int NUM_NODES    = 8,
    parameter int ID_W         = $clog2(NUM_NODES),
    parameter int GUARD_CYCLES = 2,
    parameter int TIMEOUT      = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_NODES-1:0] req,
    input  logic [NUM_NODES-1:0] done,
    output logic [NUM_NODES-1:0] grant,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic                 guard,
    output logic                 timeout_pulse,
    output logic [ID_W-1:0]      timeout_id
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    if (NUM_NODES < 2 || TIMEOUT < 2) begin : g_param_check
        $error("data_channel_arbiter: NUM_NODES and TIMEOUT must both be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        rr_ptr, rr_nxt;
    logic [GW-1:0]          gcnt, gcnt_nxt;
    logic [NUM_NODES-1:0]   grant_nxt;
    logic [ID_W-1:0]        grant_id_nxt;
    logic                   pick_vld;
    logic [ID_W-1:0]        pick_id;
    logic                   owner_release;
    logic                   hold_expire;
    logic                   grant_end;

    // Owner is tracked by grant_id, which is only meaningful in ST_GRANT.
    assign owner_release = done[grant_id] | ~req[grant_id];
    assign grant_end     = owner_release | hold_expire;

    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_NODES;
            if (!pick_vld && req[ID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    state_nxt = (GUARD_CYCLES > 0) ? ST_GUARD : ST_IDLE;
                end
            end
            ST_GUARD: begin
                if (gcnt == GUARD_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt    = '0;
        grant_id_nxt = grant_id;
        rr_nxt       = rr_ptr;
        gcnt_nxt     = gcnt;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_nxt[pick_id] = 1'b1;
                    grant_id_nxt       = pick_id;
                    rr_nxt             = (pick_id == ID_W'(NUM_NODES - 1)) ? '0 : pick_id + 1'b1;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    gcnt_nxt = '0;
                end else begin
                    grant_nxt = grant;
                end
            end
            ST_GUARD: begin
                gcnt_nxt = gcnt + 1'b1;
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            gcnt        <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            guard       <= 1'b0;
        end else begin
            rr_ptr      <= rr_nxt;
            gcnt        <= gcnt_nxt;
            grant       <= grant_nxt;
            grant_valid <= (state_nxt == ST_GRANT);
            grant_id    <= grant_id_nxt;
            guard       <= (state_nxt == ST_GUARD);
        end
    end

`ifdef DATA_CHANNEL_ARBITER_TIMEOUT_EN
    localparam int HCW = $clog2(TIMEOUT);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(TIMEOUT - 1);

    logic [HCW-1:0] hcnt;
    logic           timeout_fire;

    assign hold_expire  = (state == ST_GRANT) && (hcnt == HOLD_LAST);
    // A release landing on the expiry cycle wins: no revocation is reported.
    assign timeout_fire = hold_expire & ~owner_release;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt          <= '0;
            timeout_pulse <= 1'b0;
            timeout_id    <= '0;
        end else begin
            timeout_pulse <= timeout_fire;
            if (timeout_fire) begin
                timeout_id <= grant_id;
            end
            if (state == ST_IDLE) begin
                hcnt <= '0;
            end else if (state == ST_GRANT) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end
`else
    assign hold_expire   = 1'b0;
    assign timeout_pulse = 1'b0;
    assign timeout_id    = '0;
`endif

endmodule

// File: tb/tb_data_channel_arbiter.sv
// Directed bench for data_channel_arbiter: reset, grant/guard timing, round-robin order, fairness, timeout, async reset.
module tb_data_channel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       guard;
    logic       timeout_pulse;
    logic [2:0] timeout_id;

    int tests_run    = 0;
    int tests_failed = 0;

    data_channel_arbiter #(
        .NUM_NODES   (8),
        .ID_W        (3),
        .GUARD_CYCLES(2),
        .TIMEOUT     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .grant        (grant),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .guard        (guard),
        .timeout_pulse(timeout_pulse),
        .timeout_id   (timeout_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'hFF;
        done = '0;
        tick();
        tests_run++; if (grant !== 8'h00) begin tests_failed++; $display("FAIL reset_grant got=%h exp=00", grant); end
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_valid got=%b exp=0", grant_valid); end
        tests_run++; if (grant_id !== 3'd0) begin tests_failed++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
        tests_run++; if (guard !== 1'b0) begin tests_failed++; $display("FAIL reset_guard got=%b exp=0", guard); end
        tests_run++; if (timeout_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout_pulse got=%b exp=0", timeout_pulse); end
        tests_run++; if (timeout_id !== 3'd0) begin tests_failed++; $display("FAIL reset_timeout_id got=%0d exp=0", timeout_id); end
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_grant();
        do_reset();
        req = 8'h04;
        tick();
        tests_run++; if (grant !== 8'h04) begin tests_failed++; $display("FAIL single_grant got=%h exp=04", grant); end
        tests_run++; if (grant_id !== 3'd2) begin tests_failed++; $display("FAIL single_grant_id got=%0d exp=2", grant_id); end
        tests_run++; if (grant_valid !== 1'b1) begin tests_failed++; $display("FAIL single_grant_valid got=%b exp=1", grant_valid); end
        tick(); tick(); tick();
        tests_run++; if (grant !== 8'h04) begin tests_failed++; $display("FAIL single_hold got=%h exp=04", grant); end
        // Owner releases with done and req drop together; node 0 starts requesting.
        done = 8'h04;
        req  = 8'h01;
        tick();
        done = '0;
        tests_run++; if (grant !== 8'h00 || guard !== 1'b1 || grant_valid !== 1'b0) begin
            tests_failed++; $display("FAIL release_guard1 grant=%h guard=%b valid=%b exp=00/1/0", grant, guard, grant_valid); end
        tests_run++; if (grant_id !== 3'd2) begin tests_failed++; $display("FAIL grant_id_holds got=%0d exp=2", grant_id); end
        tick();
        tests_run++; if (guard !== 1'b1 || grant !== 8'h00) begin
            tests_failed++; $display("FAIL release_guard2 guard=%b grant=%h exp=1/00", guard, grant); end
        tick();
        tests_run++; if (guard !== 1'b0 || grant !== 8'h00) begin
            tests_failed++; $display("FAIL idle_after_guard guard=%b grant=%h exp=0/00", guard, grant); end
        tick();
        tests_run++; if (grant !== 8'h01 || grant_id !== 3'd0) begin
            tests_failed++; $display("FAIL turnaround_grant grant=%h id=%0d exp=01/0", grant, grant_id); end
        done = 8'h01;
        req  = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    task automatic test_round_robin();
        int exp_id;
        do_reset();
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_id = k % 8;
            tests_run++; if (grant !== (8'h01 << exp_id) || grant_id !== 3'(exp_id)) begin
                tests_failed++; $display("FAIL rr_order_%0d grant=%h id=%0d exp_id=%0d", k, grant, grant_id, exp_id); end
            tick();
            tick();
            tests_run++; if (!$onehot(grant)) begin tests_failed++; $display("FAIL rr_onehot_%0d grant=%h exp one-hot", k, grant); end
            done = grant;
            tick();
            done = '0;
            tests_run++; if (grant !== 8'h00 || guard !== 1'b1) begin
                tests_failed++; $display("FAIL rr_guard_%0d grant=%h guard=%b exp=00/1", k, grant, guard); end
            if (k == 8) req = '0;
            tick(); tick(); tick();
        end
    endtask

    task automatic test_non_owner();
        do_reset();
        req = 8'h20;
        tick();
        tests_run++; if (grant !== 8'h20 || grant_id !== 3'd5) begin
            tests_failed++; $display("FAIL nonowner_grant grant=%h id=%0d exp=20/5", grant, grant_id); end
        done = 8'h40;
        req  = 8'h61;
        tick();
        done = '0;
        tick();
        tests_run++; if (grant !== 8'h20 || guard !== 1'b0) begin
            tests_failed++; $display("FAIL nonowner_ignored grant=%h guard=%b exp=20/0", grant, guard); end
        req = 8'h41;
        tick();
        tests_run++; if (grant !== 8'h00 || guard !== 1'b1) begin
            tests_failed++; $display("FAIL req_drop_release grant=%h guard=%b exp=00/1", grant, guard); end
        tick(); tick(); tick();
        tests_run++; if (grant !== 8'h40 || grant_id !== 3'd6) begin
            tests_failed++; $display("FAIL next_after_5 grant=%h id=%0d exp=40/6", grant, grant_id); end
        done = 8'h40;
        req  = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    task automatic test_fairness();
        do_reset();
        req = 8'h01;
        tick();
        tests_run++; if (grant !== 8'h01) begin tests_failed++; $display("FAIL fair_first got=%h exp=01", grant); end
        done = 8'h01;
        req  = 8'h81;
        tick();
        done = '0;
        tick(); tick(); tick();
        tests_run++; if (grant !== 8'h80 || grant_id !== 3'd7) begin
            tests_failed++; $display("FAIL fair_other_first grant=%h id=%0d exp=80/7", grant, grant_id); end
        done = 8'h80;
        req  = 8'h01;
        tick();
        done = '0;
        tick(); tick(); tick();
        tests_run++; if (grant !== 8'h01 || grant_id !== 3'd0) begin
            tests_failed++; $display("FAIL fair_wrap grant=%h id=%0d exp=01/0", grant, grant_id); end
        done = 8'h01;
        req  = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h08;
        tick();
        tests_run++; if (grant !== 8'h08) begin tests_failed++; $display("FAIL to_grant got=%h exp=08", grant); end
        for (int c = 2; c <= 16; c++) tick();
        tests_run++; if (grant !== 8'h08 || timeout_pulse !== 1'b0) begin
            tests_failed++; $display("FAIL to_held16 grant=%h pulse=%b exp=08/0", grant, timeout_pulse); end
        req = 8'h18;
        tick();
`ifdef DATA_CHANNEL_ARBITER_TIMEOUT_EN
        tests_run++; if (grant !== 8'h00 || guard !== 1'b1) begin
            tests_failed++; $display("FAIL to_revoke grant=%h guard=%b exp=00/1", grant, guard); end
        tests_run++; if (timeout_pulse !== 1'b1 || timeout_id !== 3'd3) begin
            tests_failed++; $display("FAIL to_pulse pulse=%b id=%0d exp=1/3", timeout_pulse, timeout_id); end
        tick();
        tests_run++; if (timeout_pulse !== 1'b0 || timeout_id !== 3'd3) begin
            tests_failed++; $display("FAIL to_pulse_len pulse=%b id=%0d exp=0/3", timeout_pulse, timeout_id); end
        tick(); tick();
        tests_run++; if (grant !== 8'h10 || grant_id !== 3'd4) begin
            tests_failed++; $display("FAIL to_next grant=%h id=%0d exp=10/4", grant, grant_id); end
        done = 8'h10;
`else
        tests_run++; if (grant !== 8'h08 || timeout_pulse !== 1'b0 || timeout_id !== 3'd0) begin
            tests_failed++; $display("FAIL no_timeout grant=%h pulse=%b id=%0d exp=08/0/0", grant, timeout_pulse, timeout_id); end
        tick(); tick(); tick();
        tests_run++; if (grant !== 8'h08 || guard !== 1'b0) begin
            tests_failed++; $display("FAIL held_forever grant=%h guard=%b exp=08/0", grant, guard); end
        done = 8'h08;
`endif
        req = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'h10;
        tick();
        tests_run++; if (grant !== 8'h10 || grant_id !== 3'd4) begin
            tests_failed++; $display("FAIL ar_grant grant=%h id=%0d exp=10/4", grant, grant_id); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (grant !== 8'h00 || guard !== 1'b0 || grant_id !== 3'd0 || grant_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ar_immediate grant=%h guard=%b id=%0d valid=%b exp=00/0/0/0", grant, guard, grant_id, grant_valid); end
        tick();
        tests_run++; if (guard !== 1'b0 || grant !== 8'h00) begin
            tests_failed++; $display("FAIL ar_no_guard guard=%b grant=%h exp=0/00", guard, grant); end
        rst = 1'b0;
        tick();
        tests_run++; if (grant !== 8'h10 || grant_id !== 3'd4) begin
            tests_failed++; $display("FAIL ar_regrant grant=%h id=%0d exp=10/4", grant, grant_id); end
        done = 8'h10;
        req  = '0;
        tick();
        done = '0;
        tick(); tick();
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        done = '0;
        test_reset();
        test_single_grant();
        test_round_robin();
        test_non_owner();
        test_fairness();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
